// File: rtl/exec_unit_if.sv
// Execute-stage request/write-back bundle between the issue logic and exec_unit.
// The master drives the request; the slave returns busy and the write-back strobe.
interface exec_unit_if #(
    parameter int WIDTH = 16,
    parameter int RBITS = 3
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [RBITS-1:0] dst;
    logic             busy;
    logic             wb_en;
    logic [RBITS-1:0] wb_reg;
    logic [WIDTH-1:0] wb_data;
    logic             zero;
    logic             carry;
    logic             err;

    modport master (
        output start, op, opa, opb, dst,
        input  busy, wb_en, wb_reg, wb_data, zero, carry, err
    );

    modport slave (
        input  start, op, opa, opb, dst,
        output busy, wb_en, wb_reg, wb_data, zero, carry, err
    );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops with a one-cycle write-back strobe, plus iterative MUL.
// Build option EXEC_MUL_EN includes the shift-add multiplier; without it opcode 111 pulses err.
module exec_unit #(
    parameter int WIDTH = 16,
    parameter int RBITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    exec_unit_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic             accept;
    logic             busy;
    logic [WIDTH:0]   alu_res_p0;
    logic             wb_en_p1;
    logic [RBITS-1:0] wb_reg_p1;
    logic [WIDTH-1:0] wb_data_p1;
    logic             zero_p1;
    logic             carry_p1;
    logic             err_p1;

    // Result is {carry, data}; carry is the ADD carry-out or SUB borrow, 0 otherwise.
    function automatic logic [WIDTH:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {(a < b), a - b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_SHL:  r = {1'b0, a << b[3:0]};
            OP_SHR:  r = {1'b0, a >> b[3:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign accept     = bus.start && !busy;
    assign alu_res_p0 = alu(bus.op, bus.opa, bus.opb);

`ifdef EXEC_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic [RBITS-1:0] dst_mul;
    logic             last_iter;
    logic             mul_done;

    assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign mul_done  = (state == S_MUL) && last_iter;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && bus.op == OP_MUL) state_nxt = S_MUL;
            S_MUL:   if (last_iter) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_MUL);
    end

    // Shift-add iteration: one multiplier bit per clock, WIDTH clocks total.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            dst_mul <= '0;
        end else if (accept && bus.op == OP_MUL) begin
            mcand   <= bus.opa;
            mplier  <= bus.opb;
            acc     <= '0;
            cnt     <= '0;
            dst_mul <= bus.dst;
        end else if (state == S_MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end
`else
    assign busy = 1'b0;
`endif

    // Write-back stage: strobe lasts one cycle, data/flags hold until the next strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_en_p1   <= 1'b0;
            wb_reg_p1  <= '0;
            wb_data_p1 <= '0;
            zero_p1    <= 1'b0;
            carry_p1   <= 1'b0;
            err_p1     <= 1'b0;
        end else begin
            wb_en_p1 <= 1'b0;
            err_p1   <= 1'b0;
            if (accept && bus.op != OP_MUL) begin
                wb_en_p1   <= 1'b1;
                wb_reg_p1  <= bus.dst;
                wb_data_p1 <= alu_res_p0[WIDTH-1:0];
                carry_p1   <= alu_res_p0[WIDTH];
                zero_p1    <= (alu_res_p0[WIDTH-1:0] == '0);
            end
`ifdef EXEC_MUL_EN
            else if (mul_done) begin
                wb_en_p1   <= 1'b1;
                wb_reg_p1  <= dst_mul;
                wb_data_p1 <= acc_nxt;
                carry_p1   <= 1'b0;
                zero_p1    <= (acc_nxt == '0);
            end
`else
            else if (accept) begin
                err_p1 <= 1'b1;
            end
`endif
        end
    end

    assign bus.busy    = busy;
    assign bus.wb_en   = wb_en_p1;
    assign bus.wb_reg  = wb_reg_p1;
    assign bus.wb_data = wb_data_p1;
    assign bus.zero    = zero_p1;
    assign bus.carry   = carry_p1;
    assign bus.err     = err_p1;
endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed steps plus random traffic against a behavioural model.
module tb_exec_unit;
    localparam int WIDTH = 16;
    localparam int RBITS = 3;
`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    exec_unit_if #(.WIDTH(WIDTH), .RBITS(RBITS)) bus ();

    exec_unit #(.WIDTH(WIDTH), .RBITS(RBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: cycles left on a pending multiply plus the expected visible outputs.
    int          m_left = 0;
    logic [15:0] m_res  = '0;
    logic [2:0]  m_dst  = '0;
    logic        e_busy = 0, e_wb_en = 0, e_zero = 0, e_carry = 0, e_err = 0;
    logic [2:0]  e_wb_reg  = '0;
    logic [15:0] e_wb_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic writeback(input logic [2:0] d, input longint unsigned res, input bit c);
        e_wb_en   = 1'b1;
        e_wb_reg  = d;
        e_wb_data = res[15:0];
        e_zero    = (res == 0);
        e_carry   = c;
    endtask

    task automatic model_edge(input logic s, input logic [2:0] o, input logic [15:0] a,
                              input logic [15:0] b, input logic [2:0] d, input logic r);
        longint unsigned la, lb, full;
        la = longint'(a);
        lb = longint'(b);
        e_wb_en = 1'b0;
        e_err   = 1'b0;
        if (!r) begin
            m_left = 0;
            e_wb_reg = '0; e_wb_data = '0; e_zero = 1'b0; e_carry = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) writeback(m_dst, longint'(m_res), 1'b0);
        end else if (s) begin
            case (o)
                3'd0: begin full = la + lb; writeback(d, full % 65536, full >= 65536); end
                3'd1: writeback(d, (la + 65536 - lb) % 65536, la < lb);
                3'd2: writeback(d, longint'(a & b), 1'b0);
                3'd3: writeback(d, longint'(a | b), 1'b0);
                3'd4: writeback(d, longint'(a ^ b), 1'b0);
                3'd5: writeback(d, (la * (64'd1 << (lb % 16))) % 65536, 1'b0);
                3'd6: writeback(d, la / (64'd1 << (lb % 16)), 1'b0);
                default: begin
                    if (MUL_EN) begin
                        m_left = WIDTH;
                        full   = (la * lb) % 65536;
                        m_res  = full[15:0];
                        m_dst  = d;
                    end else begin
                        e_err = 1'b1;
                    end
                end
            endcase
        end
        e_busy = (m_left > 0);
    endtask

    task automatic cycle(input logic s, input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] d, input logic r);
        bus.start = s; bus.op = o; bus.opa = a; bus.opb = b; bus.dst = d;
        rst_n = r;
        @(posedge clk);
        model_edge(s, o, a, b, d, r);
        #1;
        cyc++;
        chk("busy",    bus.busy,    e_busy);
        chk("wb_en",   bus.wb_en,   e_wb_en);
        chk("wb_reg",  bus.wb_reg,  e_wb_reg);
        chk("wb_data", bus.wb_data, e_wb_data);
        chk("zero",    bus.zero,    e_zero);
        chk("carry",   bus.carry,   e_carry);
        chk("err",     bus.err,     e_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b1);
    endtask

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.opa = '0; bus.opb = '0; bus.dst = '0;

        cycle(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
        idle(1);

        cycle(1'b1, 3'd0, 16'd5, 16'd3, 3'd2, 1'b1);
        chk("add_data", bus.wb_data, 32'd8);
        chk("add_reg",  bus.wb_reg,  32'd2);
        idle(1);
        chk("add_strobe_off", bus.wb_en, 32'd0);

        cycle(1'b1, 3'd1, 16'd3, 16'd5, 3'd3, 1'b1);
        chk("sub_data",  bus.wb_data, 32'hFFFE);
        chk("sub_carry", bus.carry,   32'd1);
        cycle(1'b1, 3'd0, 16'hFFFF, 16'h0001, 3'd4, 1'b1);
        chk("add_wrap_data", bus.wb_data, 32'd0);
        chk("add_wrap_zero", bus.zero,    32'd1);
        cycle(1'b1, 3'd5, 16'h0001, 16'h0013, 3'd5, 1'b1);
        chk("shl_data", bus.wb_data, 32'h0008);
        cycle(1'b1, 3'd6, 16'h8000, 16'h000F, 3'd0, 1'b1);
        chk("shr_data", bus.wb_data, 32'h0001);
        chk("shr_reg",  bus.wb_reg,  32'd0);
        idle(2);

        cycle(1'b1, 3'd7, 16'd5, 16'd3, 3'd1, 1'b1);
        idle(16);
`ifdef EXEC_MUL_EN
        chk("mul_data", bus.wb_data, 32'd15);
        chk("mul_reg",  bus.wb_reg,  32'd1);
`endif
        idle(1);

        cycle(1'b1, 3'd7, 16'h0100, 16'h0100, 3'd6, 1'b1);
        idle(17);

        cycle(1'b1, 3'd7, 16'hABCD, 16'h1234, 3'd7, 1'b1);
        for (int i = 0; i < 17; i++) cycle(1'b1, 3'd0, 16'd100, 16'd23, 3'd2, 1'b1);
        idle(2);

        cycle(1'b1, 3'd7, 16'h00FF, 16'h0F0F, 3'd3, 1'b1);
        idle(7);
        cycle(1'b0, 3'd0, 16'h0, 16'h0, 3'd0, 1'b0);
        idle(20);

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), rand_operand(),
                  rand_operand(), 3'($urandom_range(0, 7)), ($urandom_range(0, 99) != 0));
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
